// File: rtl/nmse_seq.sv
// nmse_seq: streaming regression statistics accumulator with a time-shared
// multiplier that scores a (beta0, beta1) pair as n*MSE against the window.
module nmse_seq #(
  parameter int DW   = 16,
  parameter int BW   = 32,
  parameter int FRAC = 16,
  parameter int NW   = 16,
  parameter int OW   = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x,
  input  logic [DW-1:0] s_y,
  input  logic          c_req,
  output logic          c_ack,
  input  logic [BW-1:0] c_beta0,
  input  logic [BW-1:0] c_beta1,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_nmse,
  output logic [NW-1:0] m_n,
  output logic          m_sat,
  output logic          n_ovf
);

  localparam int SW = DW + NW;       // sum of x / y
  localparam int QW = 2 * DW + NW;   // sum of products / squares
  localparam int MB = QW + BW;       // wide multiplier port
  localparam int PW = BW + MB;       // full product
  localparam int RW = PW + 4;        // combine accumulator, carry headroom

  typedef enum logic [1:0] {ACC, CALC, OUT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           step_q, step_d;
  logic [NW-1:0]        n_q, n_d;
  logic                 n_ovf_q, n_ovf_d;
  logic signed [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic signed [QW-1:0] sxy_q, sxy_d, sxx_q, sxx_d, syy_q, syy_d;
  logic signed [BW-1:0] b0_q, b0_d, b1_q, b1_d;
  logic signed [MB-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
  logic signed [RW-1:0] acc_q, acc_d;
  logic [OW-1:0]        nmse_q, nmse_d;
  logic [NW-1:0]        mn_q, mn_d;
  logic                 sat_q, sat_d;
  logic                 mvld_q, mvld_d;
  logic                 ack_q, ack_d;

  logic signed [DW-1:0]   xs, ys;
  logic signed [2*DW-1:0] pxy, pxx, pyy;
  logic signed [BW-1:0]   mul_a;
  logic signed [MB-1:0]   mul_b;
  logic signed [PW-1:0]   mul_p;
  logic signed [RW-1:0]   acc_sh;

  assign xs     = s_x;
  assign ys     = s_y;
  assign pxy    = xs * ys;
  assign pxx    = xs * xs;
  assign pyy    = ys * ys;
  assign mul_p  = mul_a * mul_b;
  assign acc_sh = acc_q >>> FRAC;

  assign s_ready = (state_q == ACC);
  assign c_ack   = ack_q;
  assign m_valid = mvld_q;
  assign m_nmse  = nmse_q;
  assign m_n     = mn_q;
  assign m_sat   = sat_q;
  assign n_ovf   = n_ovf_q;

  // Multiplier operand schedule. A beta always sits on the narrow port, so the
  // beta-squared terms are formed as beta*(beta*stat) from stored partials.
  always_comb begin
    mul_a = b0_q;
    mul_b = '0;
    case (step_q)
      4'd0:    begin mul_a = b0_q; mul_b = {{(MB-NW){1'b0}}, n_q}; end
      4'd1:    begin mul_a = b0_q; mul_b = MB'(sx_q);  end
      4'd2:    begin mul_a = b1_q; mul_b = MB'(sxx_q); end
      4'd3:    begin mul_a = b0_q; mul_b = t0_q;       end
      4'd4:    begin mul_a = b1_q; mul_b = t1_q;       end
      4'd5:    begin mul_a = b1_q; mul_b = t2_q;       end
      4'd6:    begin mul_a = b0_q; mul_b = MB'(sy_q);  end
      4'd7:    begin mul_a = b1_q; mul_b = MB'(sxy_q); end
      default: begin mul_a = b0_q; mul_b = '0;         end
    endcase
  end

  // Next-state: accumulation, request capture, combine sequence, output hold.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    n_d     = n_q;
    n_ovf_d = n_ovf_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sxy_d   = sxy_q;
    sxx_d   = sxx_q;
    syy_d   = syy_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    acc_d   = acc_q;
    nmse_d  = nmse_q;
    mn_d    = mn_q;
    sat_d   = sat_q;
    mvld_d  = mvld_q;
    ack_d   = 1'b0;

    case (state_q)
      ACC: begin
        if (s_valid) begin
          sx_d  = sx_q + SW'(xs);
          sy_d  = sy_q + SW'(ys);
          sxy_d = sxy_q + QW'(pxy);
          sxx_d = sxx_q + QW'(pxx);
          syy_d = syy_q + QW'(pyy);
          if (n_q == {NW{1'b1}}) n_ovf_d = 1'b1;
          else                   n_d     = n_q + 1'b1;
        end
        if (c_req) begin
          b0_d    = c_beta0;
          b1_d    = c_beta1;
          ack_d   = 1'b1;
          step_d  = 4'd0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step_d = step_q + 4'd1;
        case (step_q)
          4'd0: t0_d  = mul_p[MB-1:0];                          // b0*n
          4'd1: t1_d  = mul_p[MB-1:0];                          // b0*Sx
          4'd2: t2_d  = mul_p[MB-1:0];                          // b1*Sxx
          4'd3: acc_d = acc_q + RW'(mul_p);                     // b0^2*n
          4'd4: acc_d = acc_q + (RW'(mul_p) <<< 1);             // 2*b0b1*Sx
          4'd5: acc_d = acc_q + RW'(mul_p);                     // b1^2*Sxx
          4'd6: acc_d = acc_q - (RW'(mul_p) <<< (FRAC + 1));    // 2*b0*Sy
          4'd7: acc_d = acc_q - (RW'(mul_p) <<< (FRAC + 1));    // 2*b1*Sxy
          4'd8: acc_d = acc_q + (RW'(syy_q) <<< (2 * FRAC));    // Syy
          default: begin
            // A negative sum cannot occur for a correct combine; report zero.
            if (acc_q[RW-1]) begin
              nmse_d = '0;
              sat_d  = 1'b0;
            end else if (|acc_sh[RW-1:OW]) begin
              nmse_d = '1;
              sat_d  = 1'b1;
            end else begin
              nmse_d = acc_sh[OW-1:0];
              sat_d  = 1'b0;
            end
            mn_d    = n_q;
            mvld_d  = 1'b1;
            state_d = OUT;
          end
        endcase
      end
      OUT: begin
        if (m_ready) begin
          mvld_d  = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase

    if (clr) begin
      n_d     = '0;
      n_ovf_d = 1'b0;
      sx_d    = '0;
      sy_d    = '0;
      sxy_d   = '0;
      sxx_d   = '0;
      syy_d   = '0;
      mvld_d  = 1'b0;
      ack_d   = 1'b0;
      step_d  = 4'd0;
      state_d = ACC;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      step_q  <= '0;
      n_q     <= '0;
      n_ovf_q <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      sxy_q   <= '0;
      sxx_q   <= '0;
      syy_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      acc_q   <= '0;
      nmse_q  <= '0;
      mn_q    <= '0;
      sat_q   <= 1'b0;
      mvld_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      n_q     <= n_d;
      n_ovf_q <= n_ovf_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sxy_q   <= sxy_d;
      sxx_q   <= sxx_d;
      syy_q   <= syy_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      acc_q   <= acc_d;
      nmse_q  <= nmse_d;
      mn_q    <= mn_d;
      sat_q   <= sat_d;
      mvld_q  <= mvld_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_nmse_seq.sv
// tb_nmse_seq: directed + randomized bench; reference computes n*MSE directly
// as the sum of squared fixed-point residuals over the stored sample window.
module tb_nmse_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, s_valid, s_ready, c_req, c_ack, m_valid, m_ready, m_sat, n_ovf;
  logic [15:0] s_x, s_y, m_n;
  logic [31:0] c_beta0, c_beta1;
  logic [47:0] m_nmse;

  logic        clr4, s4_valid, s4_ready, c4_req, c4_ack, m4_valid, m4_ready, m4_sat, n4_ovf;
  logic [15:0] s4_x, s4_y;
  logic [31:0] c4_beta0, c4_beta1;
  logic [47:0] m4_nmse;
  logic [3:0]  m4_n;

  nmse_seq u_dut (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .c_req(c_req), .c_ack(c_ack), .c_beta0(c_beta0),
    .c_beta1(c_beta1), .m_valid(m_valid), .m_ready(m_ready), .m_nmse(m_nmse),
    .m_n(m_n), .m_sat(m_sat), .n_ovf(n_ovf)
  );

  nmse_seq #(.NW(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr4), .s_valid(s4_valid), .s_ready(s4_ready),
    .s_x(s4_x), .s_y(s4_y), .c_req(c4_req), .c_ack(c4_ack), .c_beta0(c4_beta0),
    .c_beta1(c4_beta1), .m_valid(m4_valid), .m_ready(m4_ready), .m_nmse(m4_nmse),
    .m_n(m4_n), .m_sat(m4_sat), .n_ovf(n4_ovf)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference window and the expectation for the outstanding request.
  int          qx[$];
  int          qy[$];
  logic [47:0] exp_nmse;
  logic [15:0] exp_n;
  logic        exp_sat;
  bit          exp_armed = 1'b0;

  task automatic model_calc(input logic [31:0] b0, input logic [31:0] b1);
    logic signed [127:0] r, e, xw, yw, b0w, b1w, sh;
    b0w = $signed(b0);
    b1w = $signed(b1);
    r = 0;
    foreach (qx[i]) begin
      xw = qx[i];
      yw = qy[i];
      e  = (yw <<< 16) - b0w - b1w * xw;
      r  = r + e * e;
    end
    sh = r >>> 16;
    if (sh >= (128'sd1 <<< 48)) begin
      exp_sat  = 1'b1;
      exp_nmse = '1;
    end else begin
      exp_sat  = 1'b0;
      exp_nmse = sh[47:0];
    end
    exp_n = 16'(qx.size());
  endtask

  // Every cycle a result is presented it must match the armed expectation.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (!exp_armed) chk("unexpected_valid", 128'(m_valid), 0);
      else begin
        chk("nmse", 128'(m_nmse), 128'(exp_nmse));
        chk("m_n", 128'(m_n), 128'(exp_n));
        chk("m_sat", 128'(m_sat), 128'(exp_sat));
        chk("s_ready_in_out", 128'(s_ready), 0);
      end
    end
  end

  task automatic sample(input int x, input int y);
    @(negedge clk);
    chk("s_ready_acc", 128'(s_ready), 1);
    s_valid = 1'b1; s_x = 16'(x); s_y = 16'(y);
    @(posedge clk);
    qx.push_back(x); qy.push_back(y);
    #1 s_valid = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    qx.delete(); qy.delete();
  endtask

  task automatic req(input logic [31:0] b0, input logic [31:0] b1, input int hold,
                     input bit ws, input int x, input int y);
    int cyc;
    @(negedge clk);
    if (ws) begin
      s_valid = 1'b1; s_x = 16'(x); s_y = 16'(y);
      qx.push_back(x); qy.push_back(y);
    end
    c_req = 1'b1; c_beta0 = b0; c_beta1 = b1;
    model_calc(b0, b1);
    exp_armed = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; c_req = 1'b0;
    chk("c_ack", 128'(c_ack), 1);
    cyc = 0;
    while (!m_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("c_ack_pulse", 128'(c_ack), 0);
    end
    chk("latency", 128'(cyc), 10);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      c_req = 1'b1; c_beta0 = $urandom; c_beta1 = $urandom;
      s_valid = 1'b1; s_x = 16'($urandom); s_y = 16'($urandom);
      @(posedge clk); #1;
      chk("ack_in_out", 128'(c_ack), 0);
    end
    @(negedge clk);
    c_req = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0; exp_armed = 1'b0;
    chk("valid_drop", 128'(m_valid), 0);
    chk("s_ready_back", 128'(s_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc, k, x, y;
    logic [31:0] b0, b1;
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0;
    c_req = 1'b0; c_beta0 = '0; c_beta1 = '0; m_ready = 1'b0;
    clr4 = 1'b0; s4_valid = 1'b0; s4_x = '0; s4_y = '0;
    c4_req = 1'b0; c4_beta0 = '0; c4_beta1 = '0; m4_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_s_ready", 128'(s_ready), 1);
    chk("rst_c_ack", 128'(c_ack), 0);
    chk("rst_m_valid", 128'(m_valid), 0);
    chk("rst_m_nmse", 128'(m_nmse), 0);
    chk("rst_m_n", 128'(m_n), 0);
    chk("rst_m_sat", 128'(m_sat), 0);
    chk("rst_n_ovf", 128'(n_ovf), 0);

    // Empty window scores zero regardless of beta.
    req(32'h0001_0000, 32'h0, 0, 0, 0, 0);
    chk("pin_empty", 128'(exp_nmse), 0);

    sample(1, 2); sample(2, 4); sample(3, 6);
    req(32'h0, 32'h0001_0000, 0, 0, 0, 0);
    chk("pin_14", 128'(exp_nmse), 128'h0E_0000);
    req(32'h0, 32'h0002_0000, 0, 0, 0, 0);
    chk("pin_fit", 128'(exp_nmse), 0);

    // Third sample arrives with the request; also hold the result for 5 cycles.
    clear_stats();
    sample(1, 2); sample(2, 4);
    req(32'h0000_8000, 32'h0002_0000, 5, 1, 3, 6);
    chk("pin_0p75", 128'(exp_nmse), 128'hC000);
    chk("pin_n3", 128'(exp_n), 3);

    // Abort during the combine sequence.
    sample(7, 7);
    @(negedge clk); c_req = 1'b1; c_beta0 = 32'h0001_0000; c_beta1 = 32'h0;
    @(posedge clk); #1 c_req = 1'b0;
    chk("abort_ack", 128'(c_ack), 1);
    repeat (4) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    qx.delete(); qy.delete();
    repeat (15) @(posedge clk);
    #1 chk("abort_no_valid", 128'(m_valid), 0);
    chk("abort_s_ready", 128'(s_ready), 1);
    sample(5, -3);
    req(32'h0, 32'h0, 0, 0, 0, 0);
    chk("pin_9", 128'(exp_nmse), 128'h9_0000);
    chk("pin_n1", 128'(exp_n), 1);

    // Saturation with extreme betas.
    clear_stats();
    for (int i = 0; i < 256; i++) sample(-32768, 32767);
    req(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 0);
    chk("pin_sat", 128'(exp_sat), 1);
    chk("pin_sat_val", 128'(exp_nmse), 128'hFFFF_FFFF_FFFF);

    // 4-bit counter: the 16th sample saturates n.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); s4_valid = 1'b1; s4_x = 16'd1; s4_y = 16'd1;
      @(posedge clk); #1 s4_valid = 1'b0;
      if (i == 14) chk("ovf4_at_15", 128'(n4_ovf), 0);
    end
    chk("ovf4_at_16", 128'(n4_ovf), 1);
    @(negedge clk); c4_req = 1'b1;
    @(posedge clk); #1 c4_req = 1'b0;
    chk("c4_ack", 128'(c4_ack), 1);
    cyc = 0;
    while (!m4_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("latency4", 128'(cyc), 10);
    chk("m4_n", 128'(m4_n), 15);
    chk("m4_nmse", 128'(m4_nmse), 128'h10_0000);
    chk("m4_sat", 128'(m4_sat), 0);
    @(negedge clk) m4_ready = 1'b1;
    @(posedge clk); #1 m4_ready = 1'b0;
    chk("m4_drop", 128'(m4_valid), 0);
    @(negedge clk) clr4 = 1'b1;
    @(posedge clk); #1 clr4 = 1'b0;
    chk("ovf4_clr", 128'(n4_ovf), 0);

    // Randomized windows and betas.
    for (int r = 0; r < 10; r++) begin
      clear_stats();
      k = $urandom_range(0, 12);
      for (int j = 0; j < k; j++) begin
        x = $urandom_range(0, 65535) - 32768;
        y = $urandom_range(0, 65535) - 32768;
        sample(x, y);
      end
      for (int q = 0; q < 2; q++) begin
        if (r % 2 == 1) begin
          b0 = $urandom; b1 = $urandom;
        end else begin
          b0 = $urandom_range(0, 1 << 19) - (1 << 18);
          b1 = $urandom_range(0, 1 << 19) - (1 << 18);
        end
        x = $urandom_range(0, 65535) - 32768;
        y = $urandom_range(0, 65535) - 32768;
        req(b0, b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), x, y);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
